// File: rtl/calc_result_display.sv
// Calculator result display: captures an 8-bit result, converts it to decimal by
// sequential double-dabble and drives a 4-digit multiplexed seven-segment display.
// Optional build macro HEX_MODE_EN adds a hex_mode input that shows the raw byte in hex.
module calc_result_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] result,
    input  logic       is_signed,
`ifdef HEX_MODE_EN
    input  logic       hex_mode,
`endif
    output logic       busy,
    output logic       valid,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    localparam logic [6:0] GLYPH_BLANK = 7'h7F;
    localparam logic [6:0] GLYPH_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [7:0]       r_mag;
    logic [11:0]      r_bcd;
    logic             r_neg;
    logic             r_hex;
    logic [3:0]       r_iter;
    logic             r_busy;
    logic             r_valid;
    logic [6:0]       r_dig3;
    logic [6:0]       r_dig2;
    logic [6:0]       r_dig1;
    logic [6:0]       r_dig0;

    logic [CNT_W-1:0] r_refCnt;
    logic [1:0]       r_digIdx;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;

    logic             w_hexLoad;
    logic             w_neg;
    logic [7:0]       w_mag;
    logic [11:0]      w_bcdAdj;
    logic [6:0]       w_digSel;

`ifdef HEX_MODE_EN
    assign w_hexLoad = hex_mode;
`else
    assign w_hexLoad = 1'b0;
`endif

    // Active-low glyph table; codes above 9 are only reached through the hex path.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        glyph = GLYPH_BLANK;
        case (v)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
        endcase
    endfunction

    assign w_neg = is_signed & result[7];
    assign w_mag = w_neg ? (~result + 8'd1) : result;

    always_comb begin
        w_bcdAdj = r_bcd;
        if (r_bcd[3:0] >= 4'd5)  w_bcdAdj[3:0]  = r_bcd[3:0]  + 4'd3;
        if (r_bcd[7:4] >= 4'd5)  w_bcdAdj[7:4]  = r_bcd[7:4]  + 4'd3;
        if (r_bcd[11:8] >= 4'd5) w_bcdAdj[11:8] = r_bcd[11:8] + 4'd3;
    end

    // busy drops on the edge that enters DONE, so it is high for exactly nine cycles
    // and the digit registers land one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mag   <= '0;
            r_bcd   <= '0;
            r_neg   <= 1'b0;
            r_hex   <= 1'b0;
            r_iter  <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_dig3  <= GLYPH_BLANK;
            r_dig2  <= GLYPH_BLANK;
            r_dig1  <= GLYPH_BLANK;
            r_dig0  <= GLYPH_BLANK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load && w_hexLoad) begin
                        r_mag   <= result;
                        r_hex   <= 1'b1;
                        r_state <= S_DONE;
                    end else if (load) begin
                        r_mag   <= w_mag;
                        r_neg   <= w_neg;
                        r_hex   <= 1'b0;
                        r_bcd   <= '0;
                        r_iter  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (r_iter == 4'd8) begin
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_bcd  <= {w_bcdAdj[10:0], r_mag[7]};
                        r_mag  <= {r_mag[6:0], 1'b0};
                        r_iter <= r_iter + 4'd1;
                    end
                end
                S_DONE: begin
                    if (r_hex) begin
                        r_dig3 <= GLYPH_BLANK;
                        r_dig2 <= GLYPH_BLANK;
                        r_dig1 <= glyph(r_mag[7:4]);
                        r_dig0 <= glyph(r_mag[3:0]);
                    end else begin
                        r_dig3 <= r_neg ? GLYPH_DASH : GLYPH_BLANK;
                        r_dig2 <= (r_bcd[11:8] == 4'd0) ? GLYPH_BLANK : glyph(r_bcd[11:8]);
                        r_dig1 <= (r_bcd[11:4] == 8'd0) ? GLYPH_BLANK : glyph(r_bcd[7:4]);
                        r_dig0 <= glyph(r_bcd[3:0]);
                    end
                    r_valid <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_digSel = GLYPH_BLANK;
        case (r_digIdx)
            2'd0: w_digSel = r_dig0;
            2'd1: w_digSel = r_dig1;
            2'd2: w_digSel = r_dig2;
            2'd3: w_digSel = r_dig3;
        endcase
    end

    // an and seg load on the same edge from the current index, so no digit ever shows
    // another digit's segments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refCnt <= '0;
            r_digIdx <= 2'd0;
            r_an     <= 4'hF;
            r_seg    <= GLYPH_BLANK;
        end else if (r_refCnt == CNT_LAST) begin
            r_refCnt <= '0;
            r_digIdx <= r_digIdx + 2'd1;
            r_an     <= ~(4'b0001 << r_digIdx);
            r_seg    <= r_valid ? w_digSel : GLYPH_BLANK;
        end else begin
            r_refCnt <= r_refCnt + CNT_W'(1);
        end
    end

    assign busy  = r_busy;
    assign valid = r_valid;
    assign seg   = r_seg;
    assign an    = r_an;

endmodule

// File: tb/tb_calc_result_display.sv
// Self-checking bench for calc_result_display: table of decimal conversions with a
// scoreboard of expected digit glyphs, plus busy-load, mid-conversion reset and hex sequences.
module tb_calc_result_display;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] result;
    logic       isSigned;
`ifdef HEX_MODE_EN
    logic       hexMode;
`endif
    logic       busy;
    logic       valid;
    logic [6:0] seg;
    logic [3:0] an;

    int nChecks;
    int nFail;

    typedef struct {
        logic [7:0]  res;
        logic        sgn;
        logic [27:0] digs;
    } vec_t;

    vec_t        vecs[13];
    logic [27:0] expQ[$];

    calc_result_display #(.REFRESH_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .result    (result),
        .is_signed (isSigned),
`ifdef HEX_MODE_EN
        .hex_mode  (hexMode),
`endif
        .busy      (busy),
        .valid     (valid),
        .seg       (seg),
        .an        (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [27:0] mk(input logic [6:0] d3, input logic [6:0] d2,
                                       input logic [6:0] d1, input logic [6:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFail++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Drive a one-cycle load; returns positioned 1ns after the sampling edge N.
    task automatic loadPulse(input logic [7:0] r, input logic s);
        @(negedge clk);
        result   = r;
        isSigned = s;
        load     = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] r, input logic s, input logic [27:0] digs,
                                 output logic prevValid);
        prevValid = valid;
        loadPulse(r, s);
        expQ.push_back(digs);
        chk("busy_j0", {31'd0, busy}, 32'd1);
    endtask

    // Sample after edges N+fromJ .. N+toJ of the conversion started at edge N.
    task automatic waitConversion(input int fromJ, input int toJ, input logic prevValid);
        for (int j = fromJ; j <= toJ; j++) begin
            @(posedge clk);
            #1;
            chk($sformatf("busy_j%0d", j), {31'd0, busy}, (j <= 8) ? 32'd1 : 32'd0);
            if (j == 9)
                chk("valid_j9", {31'd0, valid}, {31'd0, prevValid});
            if (j == 10)
                chk("valid_j10", {31'd0, valid}, 32'd1);
        end
    endtask

    task automatic checkOutput();
        logic [27:0] req;
        logic [6:0]  got[4];
        logic [3:0]  seen;
        int          bad;
        chk("sb_pending", {31'd0, (expQ.size() > 0)}, 32'd1);
        if (expQ.size() == 0) return;
        req  = expQ.pop_front();
        seen = 4'h0;
        bad  = 0;
        for (int k = 0; k < 4; k++) got[k] = 7'h7F;
        repeat (16) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            case (an)
                4'hE: begin got[0] = seg; seen[0] = 1'b1; end
                4'hD: begin got[1] = seg; seen[1] = 1'b1; end
                4'hB: begin got[2] = seg; seen[2] = 1'b1; end
                4'h7: begin got[3] = seg; seen[3] = 1'b1; end
                default: bad++;
            endcase
            @(posedge clk);
            #1;
        end
        chk("an_onehot", bad, 0);
        chk("digits_seen", {28'd0, seen}, 32'hF);
        chk("seg_an3", {25'd0, got[3]}, {25'd0, req[27:21]});
        chk("seg_an2", {25'd0, got[2]}, {25'd0, req[20:14]});
        chk("seg_an1", {25'd0, got[1]}, {25'd0, req[13:7]});
        chk("seg_an0", {25'd0, got[0]}, {25'd0, req[6:0]});
    endtask

    initial begin
        logic pv;
        nChecks  = 0;
        nFail    = 0;
        rst      = 1'b1;
        load     = 1'b0;
        result   = 8'd0;
        isSigned = 1'b0;
`ifdef HEX_MODE_EN
        hexMode  = 1'b0;
`endif

        vecs[0]  = '{8'hFF, 1'b0, mk(7'h7F, 7'h24, 7'h12, 7'h12)};
        vecs[1]  = '{8'hFD, 1'b1, mk(7'h3F, 7'h7F, 7'h7F, 7'h30)};
        vecs[2]  = '{8'h80, 1'b1, mk(7'h3F, 7'h79, 7'h24, 7'h00)};
        vecs[3]  = '{8'h00, 1'b0, mk(7'h7F, 7'h7F, 7'h7F, 7'h40)};
        vecs[4]  = '{8'h64, 1'b0, mk(7'h7F, 7'h79, 7'h40, 7'h40)};
        vecs[5]  = '{8'hFF, 1'b1, mk(7'h3F, 7'h7F, 7'h7F, 7'h79)};
        vecs[6]  = '{8'h7F, 1'b1, mk(7'h7F, 7'h79, 7'h24, 7'h78)};
        vecs[7]  = '{8'h80, 1'b0, mk(7'h7F, 7'h79, 7'h24, 7'h00)};
        vecs[8]  = '{8'h0A, 1'b0, mk(7'h7F, 7'h7F, 7'h79, 7'h40)};
        vecs[9]  = '{8'h9C, 1'b1, mk(7'h3F, 7'h79, 7'h40, 7'h40)};
        vecs[10] = '{8'h2D, 1'b0, mk(7'h7F, 7'h7F, 7'h19, 7'h12)};
        vecs[11] = '{8'hF6, 1'b1, mk(7'h3F, 7'h7F, 7'h79, 7'h40)};
        vecs[12] = '{8'hFD, 1'b0, mk(7'h7F, 7'h24, 7'h12, 7'h30)};

        // Reset values, then the refresh scan E,D,B,7 every four clocks.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            case (k)
                3:  chk("scan_k3_an", {28'd0, an}, 32'hF);
                4:  chk("scan_k4_an", {28'd0, an}, 32'hE);
                8:  chk("scan_k8_an", {28'd0, an}, 32'hD);
                12: chk("scan_k12_an", {28'd0, an}, 32'hB);
                16: chk("scan_k16_an", {28'd0, an}, 32'h7);
                default: ;
            endcase
            if (k >= 4) chk($sformatf("scan_k%0d_seg", k), {25'd0, seg}, 32'h7F);
        end

        for (int v = 0; v < 13; v++) begin
            applyStimulus(vecs[v].res, vecs[v].sgn, vecs[v].digs, pv);
            waitConversion(1, 10, pv);
            checkOutput();
        end

        // A load arriving mid-conversion is dropped and does not restart the count.
        applyStimulus(8'd7, 1'b0, mk(7'h7F, 7'h7F, 7'h7F, 7'h78), pv);
        waitConversion(1, 2, pv);
        loadPulse(8'd99, 1'b0);
        chk("busy_j3", {31'd0, busy}, 32'd1);
        waitConversion(4, 10, pv);
        checkOutput();
        applyStimulus(8'd99, 1'b0, mk(7'h7F, 7'h7F, 7'h10, 7'h10), pv);
        waitConversion(1, 10, pv);
        checkOutput();

        // Reset during conversion clears everything without waiting for a clock.
        loadPulse(8'd200, 1'b0);
        waitConversion(1, 4, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_seg", {25'd0, seg}, 32'h7F);
        chk("midrst_an", {28'd0, an}, 32'hF);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef HEX_MODE_EN
        hexMode = 1'b1;
        loadPulse(8'hA3, 1'b0);
        chk("hex_busy_j0", {31'd0, busy}, 32'd0);
        chk("hex_valid_j0", {31'd0, valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("hex_busy_j1", {31'd0, busy}, 32'd0);
        chk("hex_valid_j1", {31'd0, valid}, 32'd1);
        hexMode = 1'b0;
        expQ.push_back(mk(7'h7F, 7'h7F, 7'h08, 7'h30));
        checkOutput();
`endif

        applyStimulus(8'd0, 1'b0, mk(7'h7F, 7'h7F, 7'h7F, 7'h40), pv);
        waitConversion(1, 10, pv);
        checkOutput();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
